// File: rtl/gsau_issue_ctrl.sv
// GSAU issue/return controller: loads weight rows, issues tagged activation beats to the
// systolic array, re-attaches tags to array results in order and hands them to writeback.
module gsau_issue_ctrl #(
    parameter int DW       = 512,
    parameter int TAGW     = 8,
    parameter int ROWS     = 16,
    parameter int INFLIGHT = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [DW-1:0]   vdata,
    input  logic [DW-1:0]   vpartial,
    input  logic            valid,
    input  logic            sb_valid,
    input  logic            sb_weight,
    input  logic [TAGW-1:0] sb_vdst,
    output logic            ready,
    output logic [DW-1:0]   array_in,
    output logic [DW-1:0]   array_in_partials,
    output logic            input_en,
    output logic            weight_en,
    output logic            partial_en,
    input  logic            fifo_has_space,
    input  logic [DW-1:0]   array_output,
    input  logic            out_en,
    output logic [DW-1:0]   psum,
    output logic [TAGW-1:0] wbdst,
    output logic            wb_valid,
    input  logic            output_ready,
    output logic            svalid,
    output logic [TAGW-1:0] vdst,
    output logic            err,
    output logic [0:0]      dbg_wstate
);

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int OW = $clog2(INFLIGHT + 1);
    localparam int PW = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;

    localparam logic [0:0] W_LOAD  = 1'b0;
    localparam logic [0:0] W_READY = 1'b1;

    // Handshakes: an issue fires when valid & sb_valid & ready in the same cycle; a writeback
    // fires when wb_valid & output_ready. out_en is a one-cycle strobe with no backpressure.

    logic [0:0]      state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;

    logic [DW-1:0]   array_in_q, array_in_d;
    logic [DW-1:0]   partials_q, partials_d;
    logic            weight_en_q, weight_en_d;
    logic            input_en_q, input_en_d;
    logic            partial_en_q, partial_en_d;
    logic            err_q, err_d;

    logic [TAGW-1:0] tag_mem_q [INFLIGHT];
    logic [TAGW-1:0] tag_mem_d [INFLIGHT];
    logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [OW-1:0]   tag_cnt_q, tag_cnt_d;

    logic [DW-1:0]   ob_data_q [INFLIGHT];
    logic [DW-1:0]   ob_data_d [INFLIGHT];
    logic [TAGW-1:0] ob_tag_q  [INFLIGHT];
    logic [TAGW-1:0] ob_tag_d  [INFLIGHT];
    logic [PW-1:0]   ob_wr_q, ob_wr_d, ob_rd_q, ob_rd_d;
    logic [OW-1:0]   ob_cnt_q, ob_cnt_d;

    logic can_weight, can_act, issue_fire, w_fire, a_fire;
    logic tag_push, tag_pop, wb_fire;

    // Weights may only be replaced once every issued activation has been written back.
    assign can_weight = (state_q == W_LOAD) || (outstanding_q == '0);
    assign can_act    = (state_q == W_READY) && (outstanding_q < OW'(INFLIGHT));
    assign ready      = fifo_has_space && (sb_weight ? can_weight : can_act);
    assign issue_fire = valid && sb_valid && ready;
    assign w_fire     = issue_fire && sb_weight;
    assign a_fire     = issue_fire && !sb_weight;

    assign tag_push = a_fire;
    assign tag_pop  = out_en && (tag_cnt_q != '0);
    assign wb_valid = (ob_cnt_q != '0);
    assign wb_fire  = wb_valid && output_ready;

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        outstanding_d = outstanding_q;
        array_in_d    = array_in_q;
        partials_d    = partials_q;
        weight_en_d   = w_fire;
        input_en_d    = a_fire;
        partial_en_d  = a_fire;
        err_d         = err_q | (out_en && (tag_cnt_q == '0));
        tag_mem_d     = tag_mem_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        tag_cnt_d     = tag_cnt_q;
        ob_data_d     = ob_data_q;
        ob_tag_d      = ob_tag_q;
        ob_wr_d       = ob_wr_q;
        ob_rd_d       = ob_rd_q;
        ob_cnt_d      = ob_cnt_q;

        if (w_fire) begin
            array_in_d = vdata;
            if (state_q == W_LOAD) begin
                if (wcnt_q == CW'(ROWS - 1)) begin
                    state_d = W_READY;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end else if (ROWS > 1) begin
                state_d = W_LOAD;
                wcnt_d  = CW'(1);
            end
        end

        if (a_fire) begin
            array_in_d = vdata;
            partials_d = vpartial;
        end

        if (tag_push) begin
            tag_mem_d[tag_wr_q] = sb_vdst;
            tag_wr_d            = tag_wr_q + 1'b1;
        end
        if (tag_pop) begin
            tag_rd_d = tag_rd_q + 1'b1;
        end
        case ({tag_push, tag_pop})
            2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
            2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
            default: tag_cnt_d = tag_cnt_q;
        endcase

        // A returning result takes the oldest tag; the outstanding limit keeps this buffer from overflowing.
        if (tag_pop) begin
            ob_data_d[ob_wr_q] = array_output;
            ob_tag_d[ob_wr_q]  = tag_mem_q[tag_rd_q];
            ob_wr_d            = ob_wr_q + 1'b1;
        end
        if (wb_fire) begin
            ob_rd_d = ob_rd_q + 1'b1;
        end
        case ({tag_pop, wb_fire})
            2'b10:   ob_cnt_d = ob_cnt_q + 1'b1;
            2'b01:   ob_cnt_d = ob_cnt_q - 1'b1;
            default: ob_cnt_d = ob_cnt_q;
        endcase

        case ({a_fire, wb_fire})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= W_LOAD;
            wcnt_q        <= '0;
            outstanding_q <= '0;
            array_in_q    <= '0;
            partials_q    <= '0;
            weight_en_q   <= 1'b0;
            input_en_q    <= 1'b0;
            partial_en_q  <= 1'b0;
            err_q         <= 1'b0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            tag_cnt_q     <= '0;
            ob_wr_q       <= '0;
            ob_rd_q       <= '0;
            ob_cnt_q      <= '0;
            for (int i = 0; i < INFLIGHT; i++) begin
                tag_mem_q[i] <= '0;
                ob_data_q[i] <= '0;
                ob_tag_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            outstanding_q <= outstanding_d;
            array_in_q    <= array_in_d;
            partials_q    <= partials_d;
            weight_en_q   <= weight_en_d;
            input_en_q    <= input_en_d;
            partial_en_q  <= partial_en_d;
            err_q         <= err_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            tag_cnt_q     <= tag_cnt_d;
            ob_wr_q       <= ob_wr_d;
            ob_rd_q       <= ob_rd_d;
            ob_cnt_q      <= ob_cnt_d;
            tag_mem_q     <= tag_mem_d;
            ob_data_q     <= ob_data_d;
            ob_tag_q      <= ob_tag_d;
        end
    end

    assign array_in          = array_in_q;
    assign array_in_partials = partials_q;
    assign weight_en         = weight_en_q;
    assign input_en          = input_en_q;
    assign partial_en        = partial_en_q;
    assign psum              = ob_data_q[ob_rd_q];
    assign wbdst             = ob_tag_q[ob_rd_q];
    assign svalid            = wb_fire;
    assign vdst              = ob_tag_q[ob_rd_q];
    assign err               = err_q;
    assign dbg_wstate        = state_q;

endmodule
